serial_rx_package: RTL and testbench

//  Receive-side deframer; pairs with the package transmitter on the same link.

---
 rtl/serial_rx_package_pkg.sv | 23 ++
 rtl/serial_rx_package_if.sv | 36 +++
 rtl/serial_rx_watchdog.sv | 32 +++
 rtl/serial_rx_package.sv | 140 ++++++++++++++
 tb/tb_serial_rx_package.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/serial_rx_package_pkg.sv
// serial_rx_package_pkg
//   Definitions shared by the receive and transmit sides of the package link:
//   the default frame start marker, FSM state encodings, the byte type and
//   the checksum step. The checksum is the 8-bit wraparound sum of LEN and
//   every payload byte.
package serial_rx_package_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t SYNC_DEFAULT = 8'hAA;

    // FSM encodings are kept as plain constants so older blocks can share them
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    function automatic byte_t chk_add(input byte_t sum, input byte_t b);
        return sum + b;
    endfunction

endpackage

// File: rtl/serial_rx_package_if.sv
// serial_rx_package_if
//   Groups the byte stream from the UART receiver, the host read port and
//   the status pulses of the package deframer.
//   master : byte source + host side (drives rx_data/rx_valid, rd_addr, frame_ack)
//   slave  : the deframer (drives rd_data, frame_len, frame_valid, errors, busy)
interface serial_rx_package_if #(
    parameter int ADDR_WIDTH = 4
);
    import serial_rx_package_pkg::*;

    byte_t                 rx_data;
    logic                  rx_valid;
    logic [ADDR_WIDTH-1:0] rd_addr;
    byte_t                 rd_data;
    logic [ADDR_WIDTH:0]   frame_len;
    logic                  frame_valid;
    logic                  frame_ack;
    logic                  err_checksum;
    logic                  err_length;
    logic                  err_timeout;
    logic                  overrun;
    logic                  busy;

    modport master (
        output rx_data, rx_valid, rd_addr, frame_ack,
        input  rd_data, frame_len, frame_valid,
               err_checksum, err_length, err_timeout, overrun, busy
    );

    modport slave (
        input  rx_data, rx_valid, rd_addr, frame_ack,
        output rd_data, frame_len, frame_valid,
               err_checksum, err_length, err_timeout, overrun, busy
    );

endinterface

// File: rtl/serial_rx_watchdog.sv
// serial_rx_watchdog
//   Inter-byte timeout counter. Counts enabled cycles without a clear;
//   expire is high (combinationally) on the cycle the count sits at
//   TIMEOUT-1 with no clear, so a byte arriving on that cycle wins.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart count (byte strobe)
//   en       : count only while a frame is in progress
//   expire   : timeout reached this cycle
module serial_rx_watchdog #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign expire = en && !clr && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || !en)
            cnt <= '0;
        else if (!expire)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/serial_rx_package.sv
// serial_rx_package
//   Receive-side deframer. Frame on the byte stream: SYNC, LEN, LEN payload
//   bytes, CHK. A good frame is buffered and held for the host (frame_valid)
//   until frame_ack; errors and dropped bytes are reported as 1-cycle pulses.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of serial_rx_package_if (byte stream in, read
//              port + frame_len/frame_valid/frame_ack, error pulses, busy)
module serial_rx_package
    import serial_rx_package_pkg::*;
#(
    parameter int    MAX_LEN    = 16,
    parameter int    ADDR_WIDTH = 4,
    parameter byte_t SYNC_BYTE  = SYNC_DEFAULT,
    parameter int    TIMEOUT    = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_rx_package_if.slave   bus
);

    localparam byte_t MAX_LEN_B = byte_t'(MAX_LEN);

    logic [2:0]            state;
    logic [ADDR_WIDTH:0]   len;
    logic [ADDR_WIDTH:0]   idx;
    byte_t                 sum;
    byte_t                 buffer [MAX_LEN];
    logic [ADDR_WIDTH:0]   frame_len;
    logic                  frame_valid;
    logic                  err_checksum, err_length, err_timeout, overrun;
    logic                  in_frame;
    logic                  expire;

    assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);

    serial_rx_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.rx_valid),
        .en     (in_frame),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            len          <= '0;
            idx          <= '0;
            sum          <= '0;
            frame_len    <= '0;
            frame_valid  <= 1'b0;
            err_checksum <= 1'b0;
            err_length   <= 1'b0;
            err_timeout  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            err_checksum <= 1'b0;
            err_length   <= 1'b0;
            err_timeout  <= 1'b0;
            overrun      <= 1'b0;
            // expire can only assert without a strobe, so it never races a byte
            if (expire) begin
                err_timeout <= 1'b1;
                state       <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.rx_valid && bus.rx_data == SYNC_BYTE)
                            state <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (bus.rx_valid) begin
                            // full 8-bit compare: LEN above the buffer size must not alias
                            if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
                                err_length <= 1'b1;
                                state      <= ST_IDLE;
                            end else begin
                                len   <= bus.rx_data[ADDR_WIDTH:0];
                                sum   <= bus.rx_data;
                                idx   <= '0;
                                state <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        // SYNC_BYTE is plain data here, no resync
                        if (bus.rx_valid) begin
                            sum <= chk_add(sum, bus.rx_data);
                            idx <= idx + 1'b1;
                            if (idx + 1'b1 == len)
                                state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (bus.rx_valid) begin
                            if (bus.rx_data == sum) begin
                                frame_valid <= 1'b1;
                                frame_len   <= len;
                                state       <= ST_HOLD;
                            end else begin
                                err_checksum <= 1'b1;
                                state        <= ST_IDLE;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (bus.frame_ack) begin
                            // a byte alongside the ack is treated as if already idle
                            frame_valid <= 1'b0;
                            if (bus.rx_valid && bus.rx_data == SYNC_BYTE)
                                state <= ST_LEN;
                            else
                                state <= ST_IDLE;
                        end else if (bus.rx_valid) begin
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Buffer contents survive reset; writes happen only in PAYLOAD, so a
    // held frame cannot be disturbed before the host acknowledges it.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_PAYLOAD && bus.rx_valid)
            buffer[idx[ADDR_WIDTH-1:0]] <= bus.rx_data;
    end

    assign bus.rd_data      = buffer[bus.rd_addr];
    assign bus.frame_len    = frame_len;
    assign bus.frame_valid  = frame_valid;
    assign bus.err_checksum = err_checksum;
    assign bus.err_length   = err_length;
    assign bus.err_timeout  = err_timeout;
    assign bus.overrun      = overrun;
    assign bus.busy         = in_frame;

endmodule

// File: tb/tb_serial_rx_package.sv
// tb_serial_rx_package
//   Directed-vector bench for serial_rx_package: good frame, checksum and
//   length errors, inter-byte timeout, overrun while held, ack+SYNC in the
//   same cycle, and reset mid-frame. Inputs change 1 time unit after the
//   rising edge; outputs are compared there too.
module tb_serial_rx_package;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   waited;

    always #5 clk = ~clk;

    serial_rx_package_if #(.ADDR_WIDTH(4)) bus ();

    serial_rx_package #(
        .MAX_LEN    (16),
        .ADDR_WIDTH (4),
        .SYNC_BYTE  (8'hAA),
        .TIMEOUT    (1000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one-cycle strobe, back-to-back when called repeatedly
    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        bus.rd_addr = a;
        #1;
        chk(tag, bus.rd_data, exp);
    endtask

    task automatic ack();
        bus.frame_ack = 1'b1;
        tick(1);
        bus.frame_ack = 1'b0;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_fv"},   bus.frame_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_errs"}, {bus.err_checksum, bus.err_length, bus.err_timeout, bus.overrun}, 0);
    endtask

    initial begin
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.rd_addr   = 4'd0;
        bus.frame_ack = 1'b0;

        // reset state
        tick(3);
        chk_idle_outs("rst");
        chk("rst_flen", bus.frame_len, 0);
        rst = 1'b0;
        tick(1);

        // good frame: 03+11+22+33 = 69
        send(8'hAA);
        chk("busy_len", bus.busy, 1);
        send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        chk("no_fv_before_chk", bus.frame_valid, 0);
        send(8'h69);
        chk("good_fv", bus.frame_valid, 1);
        chk("good_flen", bus.frame_len, 3);
        chk("good_busy", bus.busy, 0);
        rd("good_rd0", 4'd0, 8'h11);
        rd("good_rd1", 4'd1, 8'h22);
        rd("good_rd2", 4'd2, 8'h33);
        ack();
        chk("ack_fv", bus.frame_valid, 0);

        // bad checksum
        send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        send(8'h6A);
        chk("cs_pulse", bus.err_checksum, 1);
        chk("cs_fv", bus.frame_valid, 0);
        chk("cs_busy", bus.busy, 0);
        tick(1);
        chk("cs_pulse_end", bus.err_checksum, 0);

        // length errors, then a good frame: 02+05+06 = 0D
        send(8'hAA); send(8'h00);
        chk("len0_pulse", bus.err_length, 1);
        chk("len0_busy", bus.busy, 0);
        tick(1);
        chk("len0_pulse_end", bus.err_length, 0);
        send(8'hAA); send(8'h11);
        chk("len17_pulse", bus.err_length, 1);
        chk("len17_busy", bus.busy, 0);
        send(8'hAA); send(8'h10);
        chk("len16_ok", {bus.err_length, bus.busy}, 2'b01);
        rst = 1'b1; tick(1); rst = 1'b0;
        send(8'hAA); send(8'h02); send(8'h05); send(8'h06); send(8'h0D);
        chk("len_after_fv", bus.frame_valid, 1);
        chk("len_after_flen", bus.frame_len, 2);
        rd("len_after_rd1", 4'd1, 8'h06);
        ack();

        // timeout: 1000 cycles after the last strobe
        send(8'hAA); send(8'h02); send(8'h11);
        waited = 0;
        for (int n = 1; n <= 1200; n++) begin
            tick(1);
            if (bus.err_timeout) begin
                waited = n;
                break;
            end
        end
        chk("to_cycles", waited, 1000);
        chk("to_busy", bus.busy, 0);
        tick(1);
        chk("to_pulse_end", bus.err_timeout, 0);
        send(8'hAA); send(8'h01); send(8'hAA); send(8'hAB);
        chk("to_after_fv", bus.frame_valid, 1);
        rd("to_after_rd0", 4'd0, 8'hAA);

        // overrun while held
        send(8'h55);
        chk("ovr_pulse", bus.overrun, 1);
        chk("ovr_fv", bus.frame_valid, 1);
        rd("ovr_rd0", 4'd0, 8'hAA);
        tick(1);
        chk("ovr_pulse_end", bus.overrun, 0);

        // ack and SYNC together: straight into LEN, no overrun
        bus.frame_ack = 1'b1;
        send(8'hAA);
        bus.frame_ack = 1'b0;
        chk("ackSync_ovr", bus.overrun, 0);
        chk("ackSync_busy", bus.busy, 1);
        chk("ackSync_fv", bus.frame_valid, 0);
        send(8'h01); send(8'h7F); send(8'h80);
        chk("ackSync_fv2", bus.frame_valid, 1);
        rd("ackSync_rd0", 4'd0, 8'h7F);
        ack();

        // reset mid-frame
        send(8'hAA); send(8'h03); send(8'h11);
        rst = 1'b1;
        tick(1);
        chk_idle_outs("midrst");
        chk("midrst_flen", bus.frame_len, 0);
        rst = 1'b0;
        tick(1);
        send(8'hAA); send(8'h01); send(8'hAA); send(8'hAB);
        chk("midrst_fv", bus.frame_valid, 1);
        chk("midrst_flen2", bus.frame_len, 1);
        rd("midrst_rd0", 4'd0, 8'hAA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
